// File: rtl/mask_read_arbiter_if.sv
// Request/response bundle shared by the two mask readers and the BRAM port.
// The slave side is the arbiter; the master side is requesters plus RAM.
interface mask_read_arbiter_if #(
  parameter int ADDR_WIDTH = 19
);
  logic                  req0_valid_in;
  logic [ADDR_WIDTH-1:0] req0_addr_in;
  logic                  req0_last_in;
  logic                  req0_ready_out;
  logic                  rsp0_valid_out;
  logic                  rsp0_data_out;
  logic                  req1_valid_in;
  logic [ADDR_WIDTH-1:0] req1_addr_in;
  logic                  req1_last_in;
  logic                  req1_ready_out;
  logic                  rsp1_valid_out;
  logic                  rsp1_data_out;
  logic [ADDR_WIDTH-1:0] ram_addr_out;
  logic                  ram_data_in;

  modport slave (
    input  req0_valid_in, req0_addr_in, req0_last_in,
    input  req1_valid_in, req1_addr_in, req1_last_in,
    input  ram_data_in,
    output req0_ready_out, rsp0_valid_out, rsp0_data_out,
    output req1_ready_out, rsp1_valid_out, rsp1_data_out,
    output ram_addr_out
  );

  modport master (
    output req0_valid_in, req0_addr_in, req0_last_in,
    output req1_valid_in, req1_addr_in, req1_last_in,
    output ram_data_in,
    input  req0_ready_out, rsp0_valid_out, rsp0_data_out,
    input  req1_ready_out, rsp1_valid_out, rsp1_data_out,
    input  ram_addr_out
  );
endinterface

// File: rtl/mask_read_arbiter.sv
// Two-requester arbiter for the mask BRAM read port with burst lock + tags.
// Define MASK_ARB_RR_EN for round-robin priority; otherwise req0 always wins.
module mask_read_arbiter #(
  parameter int ADDR_WIDTH  = 19,
  parameter int RAM_LATENCY = 2
) (
  input logic clk_in,
  input logic rst_in,
  mask_read_arbiter_if.slave bus
);
  localparam int NS = RAM_LATENCY + 1;

  logic                  lock_q, lock_d;
  logic                  lock_id_q, lock_id_d;
  logic                  prio_q, prio_d;
  logic [NS-1:0]         tvld_q, tvld_d;
  logic [NS-1:0]         tid_q, tid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  dat0_q, dat0_d;
  logic                  dat1_q, dat1_d;

  logic                  gnt_id;
  logic                  rdy0, rdy1;
  logic                  acc;
  logic                  acc_last;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  fin_v;
  logic                  fin_id;
  logic                  rsp0_v, rsp1_v;

  // Pick the candidate requester; a held lock overrides priority.
  always_comb begin
    gnt_id = 1'b0;
    if (lock_q)
      gnt_id = lock_id_q;
    else if (bus.req0_valid_in && bus.req1_valid_in)
      gnt_id = prio_q;
    else
      gnt_id = bus.req1_valid_in;
    rdy0     = !rst_in && !gnt_id && bus.req0_valid_in;
    rdy1     = !rst_in &&  gnt_id && bus.req1_valid_in;
    acc      = rdy0 || rdy1;
    acc_last = gnt_id ? bus.req1_last_in : bus.req0_last_in;
    acc_addr = gnt_id ? bus.req1_addr_in : bus.req0_addr_in;
  end

  assign bus.req0_ready_out = rdy0;
  assign bus.req1_ready_out = rdy1;

  // Lock, priority, tag shift and issue-address next state.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    prio_d    = prio_q;
    if (acc) begin
      lock_d = !acc_last;
      if (!acc_last)
        lock_id_d = gnt_id;
    end
`ifdef MASK_ARB_RR_EN
    if (acc && acc_last)
      prio_d = ~gnt_id;
`else
    prio_d = 1'b0;
`endif
    tvld_d = {tvld_q[NS-2:0], acc};
    tid_d  = {tid_q[NS-2:0], acc & gnt_id};
    addr_d = acc ? acc_addr : addr_q;
  end

  assign bus.ram_addr_out = addr_q;

  // Route returning BRAM data to the requester named by the oldest tag.
  always_comb begin
    fin_v  = tvld_q[NS-1] && !rst_in;
    fin_id = tid_q[NS-1];
    rsp0_v = fin_v && !fin_id;
    rsp1_v = fin_v &&  fin_id;
    dat0_d = rsp0_v ? bus.ram_data_in : dat0_q;
    dat1_d = rsp1_v ? bus.ram_data_in : dat1_q;
  end

  assign bus.rsp0_valid_out = rsp0_v;
  assign bus.rsp1_valid_out = rsp1_v;
  assign bus.rsp0_data_out  = dat0_d;
  assign bus.rsp1_data_out  = dat1_d;

  // State registers; reset flushes in-flight tags and releases the lock.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      prio_q    <= 1'b0;
      tvld_q    <= '0;
      tid_q     <= '0;
      addr_q    <= '0;
      dat0_q    <= 1'b0;
      dat1_q    <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      prio_q    <= prio_d;
      tvld_q    <= tvld_d;
      tid_q     <= tid_d;
      addr_q    <= addr_d;
      dat0_q    <= dat0_d;
      dat1_q    <= dat1_d;
    end
  end
endmodule
